cache_bank_ctrl: RTL
====================

Name: cache_bank_ctrl

Overview:
Request-side controller that sits directly upstream of the dual-port cache bank SRAM and drives it. It accepts two independent request streams (A, B) with valid/ready handshakes and resolves same-address hazards. It keeps a per-line written flag, which the bank itself lacks, and returns registered responses carrying data plus a hit flag. It also runs a sequenced flush that zeroes the bank and clears all flags.

Parameters:
ADDR_W, 8, line address width
DATA_W, 32, data width
LINES, 256, number of lines (= 2**ADDR_W)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
reqValid_A / reqValid_B  input  1  request present
reqReady_A / reqReady_B  output  1  request accepted this cycle when valid&ready
reqWrite_A / reqWrite_B  input  1  1=write, 0=read
reqAddr_A / reqAddr_B  input  ADDR_W  line address
reqData_A / reqData_B  input  DATA_W  write data
rspValid_A / rspValid_B  output  1  one-cycle response strobe
rspData_A / rspData_B  output  DATA_W  read data (0 for writes and for unwritten lines)
rspHit_A / rspHit_B  output  1  line's written flag as sampled at accept
bankAddr_A / bankAddr_B  output  ADDR_W  to bank AA/AB
bankData_A / bankData_B  output  DATA_W  to bank DA/DB
bankWen_A / bankWen_B  output  1  to bank WENA/WENB, active-low
bankCen  output  1  to bank CENA/CENB, active-low; low when either port is accepted or a flush is active
bankQ_A / bankQ_B  input  DATA_W  from bank QA/QB; valid one cycle after the access
flushReq  input  1  start a flush (level sampled in IDLE)
flushBusy  output  1  flush in progress
flushDone  output  1  one-cycle pulse at flush completion

Behaviour:
- Reset (reset=0, async): written[LINES-1:0]=0; state=IDLE; flushCnt=0; every rsp* output=0; flushBusy=0; flushDone=0. Bank outputs are combinational: bankWen_A/B=1, bankCen=1.
- Acceptance:
  - reqReady_A = ~flushBusy.
  - reqReady_B = ~flushBusy & ~conflict.
  - conflict = reqValid_A & (reqAddr_A==reqAddr_B) & (reqWrite_A | reqWrite_B).
  - Same-address read/read is allowed in the same cycle. On any same-address pair involving a write, A wins and B stalls one cycle.
- Bank drive (combinational, per port X):
  - bankAddr_X = reqAddr_X.
  - bankData_X = reqData_X.
  - bankWen_X = ~(accX & reqWrite_X).
  - If a port is not accepted, its bankWen_X=1.
- Written flags: on an accepted write, written[addr]<=1 at that edge. No other event sets a flag; only flush and reset clear them.
- Response latency is exactly 1 cycle. In the cycle after acceptance:
  - rspValid_X=1.
  - rspHit_X = written[addr] as sampled in the accept cycle, before that cycle's update.
  - Read: rspData_X = rspHit_X ? bankQ_X : 0.
  - Write: rspData_X = 0.
  - With no acceptance, rspValid_X=0 and rspData/rspHit hold their previous values.
- Back-to-back operation: full throughput, one request per port per cycle. A read issued the cycle after a write to the same line returns hit=1 and the new data.
- Simultaneous writes to different addresses on A and B both complete in the same cycle.
- Flush FSM, states IDLE and FLUSH:
  - IDLE -> FLUSH when flushReq=1. Requests presented in that same cycle are still accepted. flushBusy=1 from the next cycle.
  - In FLUSH, each cycle: bankAddr_A=flushCnt, bankData_A=0, bankWen_A=0, bankCen=0, written[flushCnt]<=0, flushCnt<=flushCnt+1. Port B is idle (bankWen_B=1).
  - When flushCnt==LINES-1: clear that line, flushCnt wraps to 0, state->IDLE, and flushDone pulses 1 in the first IDLE cycle.
  - A flush takes exactly LINES cycles of flushBusy=1.
  - flushReq while in FLUSH is ignored. flushReq held high re-triggers a new flush on return to IDLE.
  - Responses to requests accepted in the cycle before FLUSH are still delivered in the first FLUSH cycle.
- Reset asserted mid-flush aborts immediately: all flags=0, IDLE, no flushDone pulse.

Test Plan:
- Reset then read A addr 0x10 -> next cycle rspValid_A=1, rspHit_A=0, rspData_A=0; bankWen_A=1 throughout.
- Write A 0x10=0xDEADBEEF, then read A 0x10 the next cycle -> write rsp hit=0; read rsp hit=1, data=0xDEADBEEF; one request per cycle, no stalls.
- Same cycle: A writes 0x20=0x1, B reads 0x20 -> reqReady_B=0 that cycle. B is accepted the next cycle and returns hit=1, data=0x1.
- Same cycle: A reads 0x30, B reads 0x30 after a prior write of 0x55 -> both ready=1; both responses hit=1, data=0x55.
- Write 0x05 and 0xFF, pulse flushReq -> flushBusy=1 for 256 cycles, bankAddr_A sweeps 0x00..0xFF with WEN=0, DATA=0; reqReady_A/B=0; flushDone pulses once. A subsequent read of 0xFF returns hit=0.
- Pull reset low at flush cycle 100, then release -> flushBusy=0, no flushDone, flushCnt=0; a read of 0x05 written before the flush returns hit=0.

Source files
------------

// File: rtl/cache_bank_ctrl.sv
// Request-side controller for a dual-port cache bank: hazard-resolved acceptance,
// per-line written flags, one-cycle responses and a sequenced zeroing flush.
module cache_bank_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LINES  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqValid_A,
  input  logic              reqValid_B,
  output logic              reqReady_A,
  output logic              reqReady_B,
  input  logic              reqWrite_A,
  input  logic              reqWrite_B,
  input  logic [ADDR_W-1:0] reqAddr_A,
  input  logic [ADDR_W-1:0] reqAddr_B,
  input  logic [DATA_W-1:0] reqData_A,
  input  logic [DATA_W-1:0] reqData_B,
  output logic              rspValid_A,
  output logic              rspValid_B,
  output logic [DATA_W-1:0] rspData_A,
  output logic [DATA_W-1:0] rspData_B,
  output logic              rspHit_A,
  output logic              rspHit_B,
  output logic [ADDR_W-1:0] bankAddr_A,
  output logic [ADDR_W-1:0] bankAddr_B,
  output logic [DATA_W-1:0] bankData_A,
  output logic [DATA_W-1:0] bankData_B,
  output logic              bankWen_A,
  output logic              bankWen_B,
  output logic              bankCen,
  input  logic [DATA_W-1:0] bankQ_A,
  input  logic [DATA_W-1:0] bankQ_B,
  input  logic              flushReq,
  output logic              flushBusy,
  output logic              flushDone
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(LINES - 1);

  state_t            state, stateNext;
  logic [ADDR_W-1:0] flushCnt;
  logic [LINES-1:0]  written;
  logic              conflict;
  logic              accA, accB;
  logic              flushLast;
  logic              vldA_p1, vldB_p1;
  logic              readA_p1, readB_p1;
  logic              hitA_p1, hitB_p1;
  logic [DATA_W-1:0] heldA_p1, heldB_p1;

  // A read returns bank data only for lines that have actually been written.
  function automatic logic [DATA_W-1:0] selData(input logic isRead, input logic hit,
                                                input logic [DATA_W-1:0] q);
    return (isRead && hit) ? q : '0;
  endfunction

  assign flushBusy  = (state == FLUSH);
  assign flushLast  = flushBusy && (flushCnt == LAST_LINE);
  assign conflict   = reqValid_A && (reqAddr_A == reqAddr_B) && (reqWrite_A || reqWrite_B);
  assign reqReady_A = ~flushBusy;
  assign reqReady_B = ~flushBusy & ~conflict;
  assign accA       = reqValid_A & reqReady_A;
  assign accB       = reqValid_B & reqReady_B;

  // During a flush port A is taken over to sweep zeros through every line.
  always_comb begin
    bankAddr_A = reqAddr_A;
    bankData_A = reqData_A;
    bankWen_A  = ~(accA & reqWrite_A);
    bankAddr_B = reqAddr_B;
    bankData_B = reqData_B;
    bankWen_B  = ~(accB & reqWrite_B);
    bankCen    = ~(accA | accB | flushBusy);
    if (flushBusy) begin
      bankAddr_A = flushCnt;
      bankData_A = '0;
      bankWen_A  = 1'b0;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (flushReq) stateNext = FLUSH;
      FLUSH: if (flushCnt == LAST_LINE) stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      flushCnt  <= '0;
      flushDone <= 1'b0;
    end else begin
      state     <= stateNext;
      flushDone <= flushLast;
      if (flushBusy) flushCnt <= flushCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      written <= '0;
    end else if (flushBusy) begin
      written[flushCnt] <= 1'b0;
    end else begin
      if (accA && reqWrite_A) written[reqAddr_A] <= 1'b1;
      if (accB && reqWrite_B) written[reqAddr_B] <= 1'b1;
    end
  end

  // ---- stage p1: response registers, flag sampled before this edge's update ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vldA_p1  <= 1'b0;
      vldB_p1  <= 1'b0;
      readA_p1 <= 1'b0;
      readB_p1 <= 1'b0;
      hitA_p1  <= 1'b0;
      hitB_p1  <= 1'b0;
      heldA_p1 <= '0;
      heldB_p1 <= '0;
    end else begin
      vldA_p1 <= accA;
      vldB_p1 <= accB;
      if (accA) begin
        readA_p1 <= ~reqWrite_A;
        hitA_p1  <= written[reqAddr_A];
      end
      if (accB) begin
        readB_p1 <= ~reqWrite_B;
        hitB_p1  <= written[reqAddr_B];
      end
      if (vldA_p1) heldA_p1 <= rspData_A;
      if (vldB_p1) heldB_p1 <= rspData_B;
    end
  end

  assign rspValid_A = vldA_p1;
  assign rspValid_B = vldB_p1;
  assign rspHit_A   = hitA_p1;
  assign rspHit_B   = hitB_p1;
  assign rspData_A  = vldA_p1 ? selData(readA_p1, hitA_p1, bankQ_A) : heldA_p1;
  assign rspData_B  = vldB_p1 ? selData(readB_p1, hitB_p1, bankQ_B) : heldB_p1;

endmodule
